// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transfer arbiter.
package spi_pkg;

  // Default SPI word width; must match the spi_master instance.
  localparam int DW_DEF = 10;

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESP,
    GAP
  } state_t;

  // Clock-divider select encodings understood by spi_master.
  typedef enum logic [1:0] {
    CDIV_4  = 2'b00,
    CDIV_8  = 2'b01,
    CDIV_16 = 2'b10,
    CDIV_32 = 2'b11
  } cdiv_t;

  // Index after idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ. Returns a one-hot select, its index and a valid flag.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] sel,
  output logic [PW-1:0]   sel_idx,
  output logic            vld
);

  // Scan the ring starting at ptr and keep only the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    sel     = '0;
    sel_idx = '0;
    vld     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!vld && req[(int'(ptr) + i) % NREQ]) begin
        vld                           = 1'b1;
        sel[(int'(ptr) + i) % NREQ]   = 1'b1;
        sel_idx                       = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one spi_master between NREQ requesters. Picks a requester
// round-robin, latches its config, pulses start, waits for done (with a
// timeout guard against a hung master) and returns the word with an ack.
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = DW_DEF,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_tdat,
  input  logic [NREQ*2-1:0] req_cdiv,
  input  logic [NREQ-1:0]   req_mlb,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rsp_data,
  output logic              err,
  output logic              busy,
  output logic              m_start,
  output logic [DW-1:0]     m_tdat,
  output logic [1:0]        m_cdiv,
  output logic              m_mlb,
  input  logic              m_done,
  input  logic [DW-1:0]     m_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel_idx;
  logic [CW-1:0]   cnt;
  logic            done_q;
  logic            done_pend;
  logic            done_rise;

  logic [NREQ-1:0] arb_sel;
  logic [PW-1:0]   arb_idx;
  logic            arb_vld;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr),
    .sel     (arb_sel),
    .sel_idx (arb_idx),
    .vld     (arb_vld)
  );

  // A stale high done is ignored: only a fresh 0->1 edge completes a transfer.
  assign done_rise = m_done & ~done_q;

  // Registered copy of m_done for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) done_q <= 1'b0;
    else     done_q <= m_done;
  end

  // Transfer sequencer: IDLE -> START -> WAIT -> RESP -> GAP -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel_idx   <= '0;
      cnt       <= '0;
      done_pend <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_tdat    <= '0;
      m_cdiv    <= CDIV_4;
      m_mlb     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            gnt       <= arb_sel;
            sel_idx   <= arb_idx;
            m_tdat    <= req_tdat[arb_idx*DW +: DW];
            m_cdiv    <= req_cdiv[arb_idx*2 +: 2];
            m_mlb     <= req_mlb[arb_idx];
            m_start   <= 1'b1;
            cnt       <= '0;
            done_pend <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          // A very fast master may finish while start is still held.
          if (done_rise) begin
            rsp_data  <= m_rdata;
            done_pend <= 1'b1;
          end
          if (cnt == CW'(START_CYC - 1)) begin
            m_start <= 1'b0;
            cnt     <= '0;
            state   <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT: begin
          if (done_pend || done_rise) begin
            if (!done_pend) rsp_data <= m_rdata;
            err   <= 1'b0;
            ack   <= gnt;
            state <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            err      <= 1'b1;
            ack      <= gnt;
            state    <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          ack   <= '0;
          gnt   <= '0;
          err   <= 1'b0;
          ptr   <= PW'(rr_next(int'(sel_idx), NREQ));
          state <= GAP;
        end

        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
